sample_memory_writer: RTL and testbench
=======================================

# sample_memory_writer

Write side of the pedal's 1024×8 sample memory. It accepts 8-bit audio samples over a valid/ready stream and stores them in a circular buffer. It also serves the existing addr→data read interface: 10-bit address in, 8-bit data out, one-cycle read latency. After every reset it zero-fills the whole array before accepting samples, so downstream effects never read stale data.

## Interface
Parameters:
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 8, sample width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream sample valid.
- s_data  in  DATA_W  sample value.
- s_ready  out  1  block can accept a sample this cycle.
- addr  in  ADDR_W  read address.
- data  out  DATA_W  read data, registered.
- wr_ptr  out  ADDR_W  address the next accepted sample will be written to.
- wrapped  out  1  sticky; set once wr_ptr has wrapped from DEPTH-1 to 0.
- busy  out  1  high while the post-reset clear is running.

## Operation
- States: CLEAR, RUN. Reset enters CLEAR.
- CLEAR:
  - A clear counter steps 0..DEPTH-1 and writes 0 at one address per cycle.
  - busy=1, s_ready=0.
  - After address DEPTH-1 is written, next state is RUN.
- RUN:
  - s_ready=1 and busy=0.
  - A transfer occurs when s_valid && s_ready. On a transfer, s_data is written to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
  - When wr_ptr goes from DEPTH-1 to 0, wrapped is set and stays set until reset.
- There is no back-pressure in RUN: a full buffer overwrites the oldest sample, which is intended delay-line behaviour.
- Read port:
  - Every cycle, data <= mem[addr], in any state.
  - During CLEAR, reads return 0 for addresses already cleared and undefined contents for addresses not yet cleared. Readers are expected to gate on busy.
- Read and write to the same address in the same cycle: read-first, so data shows the old contents and the new value is visible from the next read.
- Reset mid-operation:
  - Asserting rst_n low at any time immediately forces the outputs to their reset values.
  - After release, a full clear runs again.
- Reset values: s_ready=0, wr_ptr=0, wrapped=0, busy=1, data=0.
- Arithmetic: wr_ptr and the clear counter are ADDR_W bits wide and wrap naturally; there is no separate modulo logic.

## Timing
- Edge 0 is the first rising clk edge with rst_n high.
- CLEAR writes address k at edge k, for k = 0..DEPTH-1.
- At edge DEPTH-1: state becomes RUN, busy falls and s_ready rises. All three change at the same edge.
- First possible transfer is at edge DEPTH, i.e. 1024 cycles after reset release with default parameters.
- Write latency: a sample accepted at edge n is readable by an addr presented before edge n+1, and appears on data after edge n+1.
- Read latency: exactly one cycle, addr→data. data is registered and has no combinational path from addr.
- Throughput: one sample per cycle in RUN.
- wr_ptr and wrapped update on the same edge as the write.

## Structure
- Shared package `pedal_mem_pkg` holds:
  - ADDR_W and DATA_W defaults, and DEPTH;
  - `sample_t` as logic [DATA_W-1:0];
  - `mem_addr_t` as logic [ADDR_W-1:0];
  - the state enum `wr_state_e` {CLEAR, RUN}.
- Sub-module `sample_ram`: a simple dual-port RAM with one synchronous write port, one registered read-first read port, and no reset on the array. It must infer block RAM.
- `sample_memory_writer` owns the FSM, the clear counter, wr_ptr and wrapped, and muxes the RAM write port between the clear path and the sample path.

## Test plan
- Reset and clear:
  - Release rst_n and hold s_valid=1 → s_ready=0 and busy=1 for 1024 cycles.
  - At edge 1023, s_ready goes 1 and busy goes 0.
  - Reads of all 1024 addresses then return 0x00.
- Sequential write then read:
  - After clear, send 10 samples 0x01..0x0A with s_valid held high → wr_ptr=10.
  - Then, for addr=0..9, data equals 0x01..0x0A one cycle after each address is presented.
- Wrap:
  - Write 1024 samples (value = index[7:0]) and then one more sample, 0xAA → wrapped rises on the 1024th transfer.
  - wr_ptr=1 at the end.
  - mem[0]=0xAA and mem[1]=0x01.
- Read/write collision:
  - mem[5]=0x33. With wr_ptr=5, present addr=5 in the same cycle as a transfer of 0x77.
  - data=0x33 on the first read; a repeat read of addr=5 returns 0x77.
- Handshake gaps:
  - Toggle s_valid randomly over 50 cycles → wr_ptr equals the number of cycles with s_valid=1.
  - Stored values match the accepted samples, in acceptance order.
- Reset mid-RUN:
  - After 300 writes, pulse rst_n low for 3 cycles → wr_ptr=0, wrapped=0, busy=1 and data=0 while rst_n is low.
  - A fresh 1024-cycle clear follows, and address 0 then reads 0x00.

Source files
------------

// File: rtl/pedal_mem_pkg.sv
// rtl/pedal_mem_pkg.sv - shared widths, types and writer states for the pedal sample memory
package pedal_mem_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 2 ** DEFAULT_ADDR_W;

  typedef logic [DEFAULT_DATA_W-1:0] sample_t;
  typedef logic [DEFAULT_ADDR_W-1:0] mem_addr_t;

  typedef enum logic {
    CLEAR,
    RUN
  } wr_state_e;

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - simple dual-port sample RAM, one write port, registered read-first read port
module sample_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sample_memory_writer.sv
// rtl/sample_memory_writer.sv - circular sample buffer writer with post-reset zero fill and read port
module sample_memory_writer
  import pedal_mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  wr_state_e         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              xfer;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign xfer = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      wr_ptr  <= '0;
      wrapped <= 1'b0;
      busy    <= 1'b1;
      s_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          // Leaving CLEAR on the last clear write lets a sample land on the very next edge.
          if (clr_cnt == LAST_ADDR) begin
            state   <= RUN;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_ADDR) begin
              wrapped <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_ptr;
    ram_wdata = s_data;
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end else if (xfer) begin
      ram_we = 1'b1;
    end
  end

  sample_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(addr),
    .rdata(data)
  );

endmodule

// File: tb/tb_sample_memory_writer.sv
// tb/tb_sample_memory_writer.sv - self-checking bench for sample_memory_writer
module tb_sample_memory_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic [9:0] addr = 10'd0;
  logic [7:0] data;
  logic [9:0] wr_ptr;
  logic       wrapped;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] model [1024];
  logic [9:0] exp_ptr = 10'd0;
  logic       exp_wrapped = 1'b0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  sample_memory_writer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_data (s_data),
    .s_ready(s_ready),
    .addr   (addr),
    .data   (data),
    .wr_ptr (wr_ptr),
    .wrapped(wrapped),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = 8'h00;
    exp_ptr     = 10'd0;
    exp_wrapped = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_wr_ptr"},  32'(wr_ptr),  32'd0);
    check({tag, "_wrapped"}, 32'(wrapped), 32'd0);
    check({tag, "_busy"},    32'(busy),    32'd1);
    check({tag, "_data"},    32'(data),    32'd0);
  endtask

  // Releases reset with s_valid held high and waits for the clear to finish.
  task automatic release_and_clear();
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    while (cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (s_ready == busy) bad++;
      if (!busy) break;
    end
    check("clear_edges", 32'(cnt), 32'd1024);
    check("ready_busy_same_edge", 32'(bad), 32'd0);
    check("ready_after_clear", 32'(s_ready), 32'd1);
    check("ptr_after_clear", 32'(wr_ptr), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic v_en, input logic [7:0] v);
    @(negedge clk);
    s_valid = v_en;
    s_data  = v;
    check("s_ready_run", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    if (v_en) begin
      model[exp_ptr] = v;
      if (exp_ptr == 10'd1023) exp_wrapped = 1'b1;
      exp_ptr = exp_ptr + 10'd1;
    end
    check("wr_ptr", 32'(wr_ptr), 32'(exp_ptr));
    check("wrapped", 32'(wrapped), 32'(exp_wrapped));
  endtask

  task automatic rd(input logic [9:0] a);
    logic [7:0] exp;
    @(negedge clk);
    s_valid = 1'b0;
    addr    = a;
    exp_q.push_back(model[a]);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check($sformatf("rd_%0d", a), 32'(data), 32'(exp));
  endtask

  initial begin
    logic [9:0] start;
    int         nv;
    logic       vb;

    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");

    release_and_clear();
    for (int a = 0; a < 1024; a++) rd(10'(a));

    for (int i = 1; i <= 10; i++) send(1'b1, 8'(i));
    check("seq_ptr", 32'(wr_ptr), 32'd10);
    for (int a = 0; a < 10; a++) rd(10'(a));

    for (int i = 10; i < 300; i++) send(1'b1, 8'(i));
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_reset_vals("mid_rst_now");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("mid_rst_held");
    release_and_clear();
    rd(10'd0);
    rd(10'd299);

    for (int i = 0; i < 1024; i++) begin
      send(1'b1, 8'(i));
      if (i == 1022) check("wrapped_before", 32'(wrapped), 32'd0);
    end
    check("wrapped_on_1024th", 32'(wrapped), 32'd1);
    send(1'b1, 8'hAA);
    check("wrap_ptr", 32'(wr_ptr), 32'd1);
    rd(10'd0);
    rd(10'd1);
    check("wrap_mem0_model", 32'(model[0]), 32'hAA);

    for (int i = 0; i < 1028; i++) send(1'b1, (i == 4) ? 8'h33 : 8'($urandom));
    check("coll_ptr", 32'(wr_ptr), 32'd5);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h77;
    addr    = 10'd5;
    exp_q.push_back(8'h33);
    @(posedge clk);
    #1;
    check("coll_read_first", 32'(data), 32'(exp_q.pop_front()));
    model[5] = 8'h77;
    exp_ptr  = 10'd6;
    rd(10'd5);

    start = exp_ptr;
    nv    = 0;
    for (int i = 0; i < 50; i++) begin
      vb = 1'($urandom_range(0, 1));
      if (vb) nv++;
      send(vb, 8'($urandom));
    end
    check("gap_count", 32'(10'(wr_ptr - start)), 32'(nv));
    for (int i = 0; i < nv; i++) rd(start + 10'(i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
